ux607_tlwidthwidget_upsize: RTL and testbench

UX607_TLWIDTHWIDGET_UPSIZE -- requirements
Module: ux607_tlwidthwidget_upsize

---
 rtl/ux607_tlwidthwidget_upsize.sv | 232 +++++++++++++++++++++++
 tb/tb_ux607_tlwidthwidget_upsize.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ux607_tlwidthwidget_upsize.sv
// TileLink A/D width adapter between an 8-bit master and a 32-bit slave.
// Optional D-channel holding register: define UX607_TLWIDEN_D_BUF_EN.
module ux607_tlwidthwidget_upsize (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_in_a_valid,
  output logic        io_in_a_ready,
  input  logic [2:0]  io_in_a_bits_opcode,
  input  logic [2:0]  io_in_a_bits_param,
  input  logic [2:0]  io_in_a_bits_size,
  input  logic [1:0]  io_in_a_bits_source,
  input  logic [29:0] io_in_a_bits_address,
  input  logic        io_in_a_bits_mask,
  input  logic [7:0]  io_in_a_bits_data,
  output logic        io_out_a_valid,
  input  logic        io_out_a_ready,
  output logic [2:0]  io_out_a_bits_opcode,
  output logic [2:0]  io_out_a_bits_param,
  output logic [2:0]  io_out_a_bits_size,
  output logic [1:0]  io_out_a_bits_source,
  output logic [29:0] io_out_a_bits_address,
  output logic [3:0]  io_out_a_bits_mask,
  output logic [31:0] io_out_a_bits_data,
  input  logic        io_out_d_valid,
  output logic        io_out_d_ready,
  input  logic [2:0]  io_out_d_bits_opcode,
  input  logic [1:0]  io_out_d_bits_param,
  input  logic [2:0]  io_out_d_bits_size,
  input  logic [1:0]  io_out_d_bits_source,
  input  logic        io_out_d_bits_sink,
  input  logic [1:0]  io_out_d_bits_addr_lo,
  input  logic        io_out_d_bits_error,
  input  logic [31:0] io_out_d_bits_data,
  output logic        io_in_d_valid,
  input  logic        io_in_d_ready,
  output logic [2:0]  io_in_d_bits_opcode,
  output logic [1:0]  io_in_d_bits_param,
  output logic [2:0]  io_in_d_bits_size,
  output logic [1:0]  io_in_d_bits_source,
  output logic        io_in_d_bits_sink,
  output logic [1:0]  io_in_d_bits_addr_lo,
  output logic        io_in_d_bits_error,
  output logic [7:0]  io_in_d_bits_data
);

  logic [1:0]  lane_q, lane_d;
  logic [4:0]  beat_q, beat_d;
  logic [23:0] acc_data_q, acc_data_d;
  logic [2:0]  acc_mask_q, acc_mask_d;

  logic        a_is_get;
  logic [4:0]  a_beats_m1;
  logic [1:0]  a_lane;
  logic        a_last;
  logic        a_complete;
  logic        a_fire;
  logic [31:0] a_word;
  logic [3:0]  a_mask;
  logic [3:0]  a_get_mask;

  assign io_out_a_bits_opcode  = io_in_a_bits_opcode;
  assign io_out_a_bits_param   = io_in_a_bits_param;
  assign io_out_a_bits_size    = io_in_a_bits_size;
  assign io_out_a_bits_source  = io_in_a_bits_source;
  assign io_out_a_bits_address = io_in_a_bits_address;

  always_comb begin
    a_is_get = (io_in_a_bits_opcode == 3'd4);
    case (io_in_a_bits_size)
      3'd0:    a_beats_m1 = 5'd0;
      3'd1:    a_beats_m1 = 5'd1;
      3'd2:    a_beats_m1 = 5'd3;
      3'd3:    a_beats_m1 = 5'd7;
      3'd4:    a_beats_m1 = 5'd15;
      default: a_beats_m1 = 5'd31;
    endcase
    a_lane     = (beat_q == '0) ? io_in_a_bits_address[1:0] : lane_q;
    a_last     = (beat_q == a_beats_m1);
    a_complete = (a_lane == 2'd3) || a_last;
    a_word     = {8'h00, acc_data_q};
    a_word[{a_lane, 3'b000} +: 8] = io_in_a_bits_data;
    a_mask     = {1'b0, acc_mask_q};
    a_mask[a_lane] = io_in_a_bits_mask;
    case (io_in_a_bits_size)
      3'd0:    a_get_mask = 4'b0001 << io_in_a_bits_address[1:0];
      3'd1:    a_get_mask = io_in_a_bits_address[1] ? 4'b1100 : 4'b0011;
      default: a_get_mask = '1;
    endcase
  end

  always_comb begin
    if (a_is_get) begin
      io_out_a_valid      = io_in_a_valid;
      io_in_a_ready       = io_out_a_ready;
      io_out_a_bits_mask  = a_get_mask;
      io_out_a_bits_data  = '0;
    end else begin
      io_out_a_valid      = a_complete && io_in_a_valid;
      io_in_a_ready       = a_complete ? io_out_a_ready : 1'b1;
      io_out_a_bits_mask  = a_mask;
      io_out_a_bits_data  = a_word;
    end
  end

  always_comb begin
    a_fire     = io_in_a_valid && io_in_a_ready && !a_is_get;
    lane_d     = lane_q;
    beat_d     = beat_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    if (a_fire) begin
      lane_d = a_lane + 2'd1;
      beat_d = beat_q + 5'd1;
      if (a_complete) begin
        acc_data_d = '0;
        acc_mask_d = '0;
      end else begin
        acc_data_d = a_word[23:0];
        acc_mask_d = a_mask[2:0];
      end
      if (a_last) begin
        lane_d = '0;
        beat_d = '0;
      end
    end
  end

  // D source: either the downstream bus directly or the holding register
  logic        s_valid;
  logic [2:0]  s_opcode;
  logic [1:0]  s_param;
  logic [2:0]  s_size;
  logic [1:0]  s_source;
  logic        s_sink;
  logic [1:0]  s_addr_lo;
  logic        s_error;
  logic [31:0] s_data;

  logic [1:0]  d_idx_q, d_idx_d;
  logic        d_has_data;
  logic [1:0]  d_first;
  logic [1:0]  d_n_m1;
  logic [1:0]  d_lane;
  logic        d_last;
  logic        d_fire;

  always_comb begin
    d_has_data = (s_opcode == 3'd1);
    d_first    = (s_size < 3'd2) ? s_addr_lo : 2'd0;
    if (!d_has_data)         d_n_m1 = 2'd0;
    else if (s_size == 3'd0) d_n_m1 = 2'd0;
    else if (s_size == 3'd1) d_n_m1 = 2'd1;
    else                     d_n_m1 = 2'd3;
    d_lane  = d_first + d_idx_q;
    d_last  = (d_idx_q == d_n_m1);
    d_fire  = s_valid && io_in_d_ready;
    d_idx_d = d_idx_q;
    if (d_fire) d_idx_d = d_last ? '0 : d_idx_q + 2'd1;
  end

  assign io_in_d_valid        = s_valid;
  assign io_in_d_bits_opcode  = s_opcode;
  assign io_in_d_bits_param   = s_param;
  assign io_in_d_bits_size    = s_size;
  assign io_in_d_bits_source  = s_source;
  assign io_in_d_bits_sink    = s_sink;
  assign io_in_d_bits_error   = s_error;
  assign io_in_d_bits_addr_lo = d_lane;
  assign io_in_d_bits_data    = d_has_data ? s_data[{d_lane, 3'b000} +: 8] : '0;

`ifdef UX607_TLWIDEN_D_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [45:0] buf_q, buf_d;
  logic        buf_capture;

  assign io_out_d_ready = !buf_valid_q || (io_in_d_ready && d_last);
  assign buf_capture    = io_out_d_valid && io_out_d_ready;
  assign s_valid        = buf_valid_q;
  assign {s_opcode, s_param, s_size, s_source, s_sink, s_addr_lo, s_error, s_data} = buf_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (d_fire && d_last) buf_valid_d = 1'b0;
    if (buf_capture) begin
      buf_valid_d = 1'b1;
      buf_d = {io_out_d_bits_opcode, io_out_d_bits_param, io_out_d_bits_size,
               io_out_d_bits_source, io_out_d_bits_sink, io_out_d_bits_addr_lo,
               io_out_d_bits_error, io_out_d_bits_data};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
    end
  end
`else
  // Downstream holds the word until its last byte is taken upstream
  assign io_out_d_ready = io_in_d_ready && d_last;
  assign s_valid   = io_out_d_valid;
  assign s_opcode  = io_out_d_bits_opcode;
  assign s_param   = io_out_d_bits_param;
  assign s_size    = io_out_d_bits_size;
  assign s_source  = io_out_d_bits_source;
  assign s_sink    = io_out_d_bits_sink;
  assign s_addr_lo = io_out_d_bits_addr_lo;
  assign s_error   = io_out_d_bits_error;
  assign s_data    = io_out_d_bits_data;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lane_q     <= '0;
      beat_q     <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      d_idx_q    <= '0;
    end else begin
      lane_q     <= lane_d;
      beat_q     <= beat_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      d_idx_q    <= d_idx_d;
    end
  end

endmodule

// File: tb/tb_ux607_tlwidthwidget_upsize.sv
// Self-checking bench for ux607_tlwidthwidget_upsize: vector tables, directed
// multi-beat sequences and randomized A/D traffic against a byte-level model.
module tb_ux607_tlwidthwidget_upsize;
  logic        clock;
  logic        reset_n;
  logic        io_in_a_valid, io_in_a_ready;
  logic [2:0]  io_in_a_bits_opcode, io_in_a_bits_param, io_in_a_bits_size;
  logic [1:0]  io_in_a_bits_source;
  logic [29:0] io_in_a_bits_address;
  logic        io_in_a_bits_mask;
  logic [7:0]  io_in_a_bits_data;
  logic        io_out_a_valid, io_out_a_ready;
  logic [2:0]  io_out_a_bits_opcode, io_out_a_bits_param, io_out_a_bits_size;
  logic [1:0]  io_out_a_bits_source;
  logic [29:0] io_out_a_bits_address;
  logic [3:0]  io_out_a_bits_mask;
  logic [31:0] io_out_a_bits_data;
  logic        io_out_d_valid, io_out_d_ready;
  logic [2:0]  io_out_d_bits_opcode;
  logic [1:0]  io_out_d_bits_param;
  logic [2:0]  io_out_d_bits_size;
  logic [1:0]  io_out_d_bits_source;
  logic        io_out_d_bits_sink;
  logic [1:0]  io_out_d_bits_addr_lo;
  logic        io_out_d_bits_error;
  logic [31:0] io_out_d_bits_data;
  logic        io_in_d_valid, io_in_d_ready;
  logic [2:0]  io_in_d_bits_opcode;
  logic [1:0]  io_in_d_bits_param;
  logic [2:0]  io_in_d_bits_size;
  logic [1:0]  io_in_d_bits_source;
  logic        io_in_d_bits_sink;
  logic [1:0]  io_in_d_bits_addr_lo;
  logic        io_in_d_bits_error;
  logic [7:0]  io_in_d_bits_data;

  ux607_tlwidthwidget_upsize dut (
    .clock(clock), .reset_n(reset_n),
    .io_in_a_valid(io_in_a_valid), .io_in_a_ready(io_in_a_ready),
    .io_in_a_bits_opcode(io_in_a_bits_opcode), .io_in_a_bits_param(io_in_a_bits_param),
    .io_in_a_bits_size(io_in_a_bits_size), .io_in_a_bits_source(io_in_a_bits_source),
    .io_in_a_bits_address(io_in_a_bits_address), .io_in_a_bits_mask(io_in_a_bits_mask),
    .io_in_a_bits_data(io_in_a_bits_data),
    .io_out_a_valid(io_out_a_valid), .io_out_a_ready(io_out_a_ready),
    .io_out_a_bits_opcode(io_out_a_bits_opcode), .io_out_a_bits_param(io_out_a_bits_param),
    .io_out_a_bits_size(io_out_a_bits_size), .io_out_a_bits_source(io_out_a_bits_source),
    .io_out_a_bits_address(io_out_a_bits_address), .io_out_a_bits_mask(io_out_a_bits_mask),
    .io_out_a_bits_data(io_out_a_bits_data),
    .io_out_d_valid(io_out_d_valid), .io_out_d_ready(io_out_d_ready),
    .io_out_d_bits_opcode(io_out_d_bits_opcode), .io_out_d_bits_param(io_out_d_bits_param),
    .io_out_d_bits_size(io_out_d_bits_size), .io_out_d_bits_source(io_out_d_bits_source),
    .io_out_d_bits_sink(io_out_d_bits_sink), .io_out_d_bits_addr_lo(io_out_d_bits_addr_lo),
    .io_out_d_bits_error(io_out_d_bits_error), .io_out_d_bits_data(io_out_d_bits_data),
    .io_in_d_valid(io_in_d_valid), .io_in_d_ready(io_in_d_ready),
    .io_in_d_bits_opcode(io_in_d_bits_opcode), .io_in_d_bits_param(io_in_d_bits_param),
    .io_in_d_bits_size(io_in_d_bits_size), .io_in_d_bits_source(io_in_d_bits_source),
    .io_in_d_bits_sink(io_in_d_bits_sink), .io_in_d_bits_addr_lo(io_in_d_bits_addr_lo),
    .io_in_d_bits_error(io_in_d_bits_error), .io_in_d_bits_data(io_in_d_bits_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  size;
    logic [29:0] addr;
    logic        rdy;
    logic [3:0]  mask;
  } get_vec_t;

  typedef struct {
    logic [2:0]  opc;
    logic [2:0]  size;
    logic [1:0]  alo;
    logic [31:0] data;
    int          n;
    logic [31:0] eb;   // k-th expected byte at [8k+:8]
    logic [7:0]  el;   // k-th expected lane at [2k+:2]
  } d_vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          stall = 0;
  logic [7:0]  pbytes[32];
  logic        pmask[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    io_in_a_valid = 1'b1; io_in_a_bits_opcode = 3'd0; io_in_a_bits_size = 3'd2;
    io_in_a_bits_address = '0; io_out_a_ready = 1'b1;
    io_out_d_valid = 1'b0; io_out_d_bits_opcode = 3'd0; io_out_d_bits_size = 3'd0;
    io_in_d_ready = 1'b1;
    #2;
    check("rst_out_a_valid", io_out_a_valid, 1'b0);
    check("rst_in_a_ready", io_in_a_ready, 1'b1);
    check("rst_in_d_valid", io_in_d_valid, 1'b0);
    check("rst_out_d_ready", io_out_d_ready, 1'b1);
    io_in_a_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  // Put message of 2^size bytes; bytes land at consecutive byte addresses and a
  // downstream word closes at lane 3 or at the message end.
  task automatic put_msg(input logic [2:0] opc, input logic [2:0] size, input logic [29:0] addr,
                         input int max_beats, input int rdy_pct, input int vld_pct);
    int n, lim, beat, cycles, lane, exp_cnt, seen;
    bit vld, rdy, compl, fire;
    logic [31:0] w;
    logic [3:0]  m;
    logic [31:0] qd[$];
    logic [3:0]  qm[$];
    n = 1 << size;
    lim = (max_beats < n) ? max_beats : n;
    w = '0; m = '0; exp_cnt = 0; seen = 0;
    for (int i = 0; i < n; i++) begin
      lane = (int'(addr[1:0]) + i) % 4;
      w[lane*8 +: 8] = pbytes[i];
      m[lane] = pmask[i];
      if (lane == 3 || i == n - 1) begin
        qd.push_back(w); qm.push_back(m);
        if (i < lim) exp_cnt++;
        w = '0; m = '0;
      end
    end
    beat = 0; cycles = 0;
    while (beat < lim && cycles < 400) begin
      vld   = ($urandom_range(99) < vld_pct);
      lane  = (int'(addr[1:0]) + beat) % 4;
      compl = (lane == 3) || (beat == n - 1);
      rdy   = ($urandom_range(99) < rdy_pct);
      if (vld && compl && stall > 0) begin rdy = 1'b0; stall--; end
      io_in_a_valid = vld; io_in_a_bits_opcode = opc; io_in_a_bits_size = size;
      io_in_a_bits_param = 3'd0; io_in_a_bits_source = 2'd1; io_in_a_bits_address = addr;
      io_in_a_bits_data = pbytes[beat]; io_in_a_bits_mask = pmask[beat];
      io_out_a_ready = rdy;
      #2;
      if (vld) begin
        check("a_out_valid", io_out_a_valid, compl);
        check("a_in_ready", io_in_a_ready, compl ? rdy : 1'b1);
      end else begin
        check("a_out_valid_idle", io_out_a_valid, 1'b0);
      end
      if (io_out_a_valid && rdy) begin
        if (qd.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL a_extra_beat: got out beat data %h, expected none", io_out_a_bits_data);
        end else begin
          check("a_data", io_out_a_bits_data, qd.pop_front());
          check("a_mask", io_out_a_bits_mask, qm.pop_front());
          check("a_address", io_out_a_bits_address, addr);
          check("a_opcode", io_out_a_bits_opcode, opc);
          seen++;
        end
      end
      fire = vld && io_in_a_ready;
      @(posedge clock); #1;
      cycles++;
      if (fire) beat++;
    end
    io_in_a_valid = 1'b0;
    check("a_beats_taken", beat, lim);
    check("a_out_beat_count", seen, exp_cnt);
  endtask

  task automatic d_model(input logic [2:0] opc, input logic [2:0] size, input logic [1:0] alo,
                         input logic [31:0] data, output int n, output logic [31:0] eb,
                         output logic [7:0] el);
    int first, lane;
    n = (opc == 3'd1) ? ((size < 3'd2) ? (1 << size) : 4) : 1;
    first = (size < 3'd2) ? int'(alo) : 0;
    eb = '0; el = '0;
    for (int k = 0; k < n; k++) begin
      lane = (first + k) % 4;
      eb[k*8 +: 8] = (opc == 3'd1) ? data[lane*8 +: 8] : 8'h00;
      el[k*2 +: 2] = 2'(lane);
    end
  endtask

  task automatic d_resp(input logic [2:0] opc, input logic [2:0] size, input logic [1:0] alo,
                        input logic [31:0] data, input int n, input logic [31:0] eb,
                        input logic [7:0] el, input int rdy_pct);
    int idx, cycles;
    bit rdy, done;
    logic [1:0] src;
    logic       err;
    idx = 0; cycles = 0; done = 1'b0;
    src = 2'($urandom_range(3));
    err = 1'($urandom_range(1));
    io_out_d_valid = 1'b1; io_out_d_bits_opcode = opc; io_out_d_bits_size = size;
    io_out_d_bits_addr_lo = alo; io_out_d_bits_data = data; io_out_d_bits_source = src;
    io_out_d_bits_param = 2'd0; io_out_d_bits_sink = 1'b0; io_out_d_bits_error = err;
    while (!done && cycles < 200) begin
      rdy = ($urandom_range(99) < rdy_pct);
      io_in_d_ready = rdy;
      #2;
      check("d_in_valid", io_in_d_valid, 1'b1);
      check("d_byte", io_in_d_bits_data, eb[idx*8 +: 8]);
      check("d_addr_lo", io_in_d_bits_addr_lo, el[idx*2 +: 2]);
      check("d_source", io_in_d_bits_source, src);
      check("d_error", io_in_d_bits_error, err);
      check("d_out_ready", io_out_d_ready, rdy && (idx == n - 1));
      if (rdy && idx == n - 1) done = 1'b1;
      @(posedge clock); #1;
      cycles++;
      if (rdy) idx++;
    end
    io_out_d_valid = 1'b0;
    check("d_bytes_taken", idx, n);
    #1;
    check("d_in_valid_idle", io_in_d_valid, 1'b0);
    @(posedge clock); #1;
  endtask

  get_vec_t gt[7];
  d_vec_t   dt[7];

  initial begin
    gt[0] = '{3'd0, 30'h003, 1'b1, 4'b1000};
    gt[1] = '{3'd0, 30'h001, 1'b0, 4'b0010};
    gt[2] = '{3'd1, 30'h002, 1'b1, 4'b1100};
    gt[3] = '{3'd1, 30'h010, 1'b0, 4'b0011};
    gt[4] = '{3'd2, 30'h044, 1'b1, 4'b1111};
    gt[5] = '{3'd3, 30'h080, 1'b0, 4'b1111};
    gt[6] = '{3'd0, 30'h000, 1'b1, 4'b0001};
    dt[0] = '{3'd1, 3'd2, 2'd0, 32'hA1B2C3D4, 4, 32'hA1B2C3D4, 8'hE4};
    dt[1] = '{3'd1, 3'd0, 2'd2, 32'hA1B2C3D4, 1, 32'h000000B2, 8'h02};
    dt[2] = '{3'd1, 3'd1, 2'd2, 32'h55667788, 2, 32'h00005566, 8'h0E};
    dt[3] = '{3'd1, 3'd1, 2'd0, 32'h55667788, 2, 32'h00007788, 8'h04};
    dt[4] = '{3'd0, 3'd2, 2'd0, 32'hDEADBEEF, 1, 32'h00000000, 8'h00};
    dt[5] = '{3'd1, 3'd3, 2'd1, 32'h0BADF00D, 4, 32'h0BADF00D, 8'hE4};
    dt[6] = '{3'd1, 3'd0, 2'd1, 32'h12345678, 1, 32'h00000056, 8'h01};

    reset_n = 1'b0;
    io_in_a_valid = 1'b0; io_in_a_bits_opcode = '0; io_in_a_bits_param = '0;
    io_in_a_bits_size = '0; io_in_a_bits_source = '0; io_in_a_bits_address = '0;
    io_in_a_bits_mask = 1'b0; io_in_a_bits_data = '0; io_out_a_ready = 1'b1;
    io_out_d_valid = 1'b0; io_out_d_bits_opcode = '0; io_out_d_bits_param = '0;
    io_out_d_bits_size = '0; io_out_d_bits_source = '0; io_out_d_bits_sink = 1'b0;
    io_out_d_bits_addr_lo = '0; io_out_d_bits_error = 1'b0; io_out_d_bits_data = '0;
    io_in_d_ready = 1'b1;
    @(posedge clock); #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      io_in_a_valid = 1'b1; io_in_a_bits_opcode = 3'd4; io_in_a_bits_size = gt[i].size;
      io_in_a_bits_address = gt[i].addr; io_in_a_bits_data = 8'h5A; io_in_a_bits_mask = 1'b1;
      io_out_a_ready = gt[i].rdy;
      #2;
      check("get_valid", io_out_a_valid, 1'b1);
      check("get_ready", io_in_a_ready, gt[i].rdy);
      check("get_mask", io_out_a_bits_mask, gt[i].mask);
      check("get_data", io_out_a_bits_data, 32'h0);
      io_in_a_valid = 1'b0;
      @(posedge clock); #1;
    end

    for (int i = 0; i < 7; i++)
      d_resp(dt[i].opc, dt[i].size, dt[i].alo, dt[i].data, dt[i].n, dt[i].eb, dt[i].el, 60);

    pbytes[0] = 8'h11; pbytes[1] = 8'h22; pbytes[2] = 8'h33; pbytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) pmask[i] = 1'b1;
    put_msg(3'd0, 3'd2, 30'h100, 32, 100, 100);

    pbytes[0] = 8'hAB; pbytes[1] = 8'hCD; pmask[0] = 1'b1; pmask[1] = 1'b0;
    stall = 3;
    put_msg(3'd0, 3'd1, 30'h102, 32, 100, 100);

    for (int i = 0; i < 8; i++) begin pbytes[i] = 8'($urandom); pmask[i] = 1'b1; end
    put_msg(3'd1, 3'd3, 30'h000, 32, 100, 100);

    for (int i = 0; i < 4; i++) begin pbytes[i] = 8'hE0 + 8'(i); pmask[i] = 1'b1; end
    put_msg(3'd0, 3'd2, 30'h200, 2, 100, 100);
    do_reset();
    for (int i = 0; i < 4; i++) begin pbytes[i] = 8'h70 + 8'(i); pmask[i] = 1'b1; end
    put_msg(3'd0, 3'd2, 30'h200, 32, 100, 100);

    fork
      begin
        for (int m = 0; m < 30; m++) begin
          logic [2:0]  sz;
          logic [29:0] ad;
          sz = 3'($urandom_range(4));
          ad = 30'($urandom) & ~(30'((1 << sz) - 1));
          for (int i = 0; i < 32; i++) begin
            pbytes[i] = 8'($urandom); pmask[i] = 1'($urandom_range(1));
          end
          put_msg(3'($urandom_range(1)), sz, ad, 32, 70, 80);
        end
      end
      begin
        for (int r = 0; r < 30; r++) begin
          logic [2:0]  opc, sz;
          logic [1:0]  alo;
          logic [31:0] dat, eb;
          logic [7:0]  el;
          int          n;
          opc = 3'($urandom_range(1));
          sz  = 3'($urandom_range(3));
          alo = 2'($urandom_range(3));
          if (sz == 3'd1) alo[0] = 1'b0;
          dat = $urandom;
          d_model(opc, sz, alo, dat, n, eb, el);
          d_resp(opc, sz, alo, dat, n, eb, el, 70);
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
